seq_mdu_alu: RTL

//  Parametrised multi-cycle ALU for the EX stage. Covers the existing op set and adds

---
 rtl/seq_mdu_alu_if.sv | 25 ++
 rtl/seq_mdu_alu.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seq_mdu_alu_if.sv
// Handshake bundle for seq_mdu_alu: operand side (in_*) and result side (out_*).
interface seq_mdu_alu_if #(
  parameter int W   = 32,
  parameter int OPW = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [OPW-1:0]        op;
  logic signed [W-1:0]   a;
  logic signed [W-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [2*W-1:0] result;
  logic                  zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/seq_mdu_alu.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith ops plus iterative
// shift-add signed multiply and restoring signed divide on operand magnitudes.
module seq_mdu_alu #(
  parameter int W   = 32,
  parameter int OPW = 4
) (
  input logic         clk,
  input logic         rst,
  seq_mdu_alu_if.slave bus
);
  localparam int RW = 2 * W;
  localparam int CW = $clog2(W);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_AND = OPW'(2);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_SLT = OPW'(5);
  localparam logic [OPW-1:0] OP_MUL = OPW'(6);
  localparam logic [OPW-1:0] OP_DIV = OPW'(7);
  localparam logic [OPW-1:0] OP_EQ  = OPW'(8);
  localparam logic [OPW-1:0] OP_NE  = OPW'(9);

  typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, FIX, DONE} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt;
  logic                  fix_pend;
  logic signed [RW-1:0]  result_r;
  logic                  zero_r;

  logic [OPW-1:0]        op_r;
  logic signed [W-1:0]   a_r, b_r;
  logic [W-1:0]          ma, mb;
  logic [RW-1:0]         acc;

  logic signed [RW-1:0]  exec_res;
  logic                  exec_zero;
  logic [RW-1:0]         fix_val;
  logic [W:0]            mul_sum, div_sh, div_diff;

  function automatic logic [W-1:0] sign_w(input logic [W-1:0] m, input logic neg);
    return neg ? (~m + 1'b1) : m;
  endfunction

  function automatic logic [RW-1:0] sign_2w(input logic [RW-1:0] m, input logic neg);
    return neg ? (~m + 1'b1) : m;
  endfunction

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return sign_w(v, v[W-1]);
  endfunction

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_r;
  assign bus.zero      = zero_r;

  // acc holds {partial product high, multiplier} for MUL and {remainder, quotient} for DIV
  assign mul_sum  = {1'b0, acc[RW-1:W]} + {1'b0, (acc[0] ? ma : {W{1'b0}})};
  assign div_sh   = {acc[RW-1:W], acc[W-1]};
  assign div_diff = div_sh - {1'b0, mb};

  always_comb begin
    exec_res  = '0;
    exec_zero = 1'b0;
    case (op_r)
      OP_ADD: exec_res = RW'(a_r) + RW'(b_r);
      OP_SUB: exec_res = RW'(a_r) - RW'(b_r);
      OP_AND: exec_res = RW'(a_r & b_r);
      OP_OR:  exec_res = RW'(a_r | b_r);
      OP_XOR: exec_res = RW'(a_r ^ b_r);
      OP_SLT: exec_res = RW'(a_r < b_r);
      OP_EQ:  exec_zero = (a_r == b_r);
      OP_NE:  exec_zero = (a_r != b_r);
      default: ;
    endcase
  end

  // Division by zero overrides the iterated value; MIN/-1 wraps naturally.
  always_comb begin
    fix_val = acc;
    if (op_r == OP_MUL)
      fix_val = sign_2w(acc, a_r[W-1] ^ b_r[W-1]);
    else if (mb == '0)
      fix_val = {a_r, {W{1'b1}}};
    else
      fix_val = {sign_w(acc[RW-1:W], a_r[W-1]), sign_w(acc[W-1:0], a_r[W-1] ^ b_r[W-1])};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.in_valid)
              state_nx = (bus.op == OP_MUL) ? MUL : (bus.op == OP_DIV) ? DIV : EXEC;
      EXEC: state_nx = DONE;
      MUL,
      DIV:  if (cnt == CW'(W - 1)) state_nx = FIX;
      FIX:  if (fix_pend) state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      fix_pend <= 1'b0;
      result_r <= '0;
      zero_r   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= (state == MUL || state == DIV) ? cnt + 1'b1 : '0;
      // FIX spends one cycle on sign correction and one to publish the result
      fix_pend <= (state == FIX) && !fix_pend;
      if (state == EXEC) begin
        result_r <= exec_res;
        zero_r   <= exec_zero;
      end else if (state == FIX && fix_pend) begin
        result_r <= acc;
        zero_r   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (bus.in_valid) begin
              op_r <= bus.op;
              a_r  <= bus.a;
              b_r  <= bus.b;
              ma   <= mag(bus.a);
              mb   <= mag(bus.b);
              acc  <= {{W{1'b0}}, (bus.op == OP_DIV) ? mag(bus.a) : mag(bus.b)};
            end
      MUL:  acc <= {mul_sum, acc[W-1:1]};
      DIV:  acc <= div_diff[W] ? {div_sh[W-1:0], acc[W-2:0], 1'b0}
                               : {div_diff[W-1:0], acc[W-2:0], 1'b1};
      FIX:  if (!fix_pend) acc <= fix_val;
      default: ;
    endcase
  end
endmodule
